// File: rtl/pc_gen_pkg.sv
// Shared types and default constants for the pc_gen program-counter unit.
// Optional misaligned-redirect checking is enabled by defining PC_GEN_MISALIGN_CHK_EN.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_TRAP  = 2'd0,
    SRC_REDIR = 2'd1,
    SRC_SEQ   = 2'd2,
    SRC_HOLD  = 2'd3
  } src_e;

  localparam int unsigned PC_XLEN_DEF      = 32;
  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] PC_STEP_DEF      = 32'd4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake, redirect and halt signals between pc_gen and its neighbours.
// master = pc_gen side, slave = fetch/EX/CSR side.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] dnpc;
  logic            redir_valid;
  logic [XLEN-1:0] redir_base;
  logic [XLEN-1:0] redir_off;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            halt_req;
  logic            misalign_valid;
  logic [XLEN-1:0] misalign_addr;

  modport master (
    output if_valid, if_pc, dnpc, misalign_valid, misalign_addr,
    input  if_ready, redir_valid, redir_base, redir_off, trap_valid, trap_pc, halt_req
  );

  modport slave (
    input  if_valid, if_pc, dnpc, misalign_valid, misalign_addr,
    output if_ready, redir_valid, redir_base, redir_off, trap_valid, trap_pc, halt_req
  );
endinterface

// File: rtl/pc_gen_target_add.sv
// XLEN-bit modular adder; carry out is discarded so targets wrap around 2^XLEN.
module pc_gen_target_add #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: registered fetch PC with valid/ready issue, trap/branch
// redirects and halt control. Define PC_GEN_MISALIGN_CHK_EN to reject misaligned branch targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = PC_XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC_DEF),
  parameter logic [XLEN-1:0] STEP       = XLEN'(PC_STEP_DEF),
  parameter int              ALIGN_BITS = 2
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  state_e          state_p0;
  logic            vld_p0;
  logic [XLEN-1:0] pc_p0;

  logic [XLEN-1:0] redir_sum;
  logic [XLEN-1:0] seq_sum;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_ok;
  logic            fire;
  src_e            src;
  logic [XLEN-1:0] npc;

  assign fire = vld_p0 & bus.if_ready;

  pc_gen_target_add #(.XLEN(XLEN)) u_redir_add (
    .a   (bus.redir_base),
    .b   (bus.redir_off),
    .sum (redir_sum)
  );

  pc_gen_target_add #(.XLEN(XLEN)) u_seq_add (
    .a   (pc_p0),
    .b   (STEP),
    .sum (seq_sum)
  );

`ifdef PC_GEN_MISALIGN_CHK_EN
  assign redir_tgt = redir_sum;
  assign redir_ok  = ~(|(redir_sum & ALIGN_MASK));
`else
  // Without checking, a misaligned target is silently rounded down to alignment.
  assign redir_tgt = redir_sum & ~ALIGN_MASK;
  assign redir_ok  = 1'b1;
`endif

  // BOOT ignores all sources so the first issued address is always RESET_VEC.
  always_comb begin
    src = SRC_HOLD;
    if (state_p0 != BOOT) begin
      if (bus.trap_valid)                 src = SRC_TRAP;
      else if (bus.redir_valid && redir_ok) src = SRC_REDIR;
      else if (fire)                      src = SRC_SEQ;
      else                                src = SRC_HOLD;
    end
  end

  always_comb begin
    npc = pc_p0;
    case (src)
      SRC_TRAP:  npc = bus.trap_pc;
      SRC_REDIR: npc = redir_tgt;
      SRC_SEQ:   npc = seq_sum;
      default:   npc = pc_p0;
    endcase
  end

  // Stage p0: architectural PC, control state and registered fetch valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0    <= RESET_VEC;
      state_p0 <= BOOT;
      vld_p0   <= 1'b0;
    end else begin
      pc_p0 <= npc;
      case (state_p0)
        BOOT: begin
          if (bus.halt_req) begin
            state_p0 <= HALT;
            vld_p0   <= 1'b0;
          end else begin
            state_p0 <= RUN;
            vld_p0   <= 1'b1;
          end
        end
        RUN: begin
          // An issued address stays presented until accepted, even under halt.
          if (bus.halt_req && fire) begin
            state_p0 <= HALT;
            vld_p0   <= 1'b0;
          end
        end
        HALT: begin
          if (!bus.halt_req) begin
            state_p0 <= RUN;
            vld_p0   <= 1'b1;
          end
        end
        default: begin
          state_p0 <= BOOT;
          vld_p0   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_GEN_MISALIGN_CHK_EN
  logic            mis_vld_p0;
  logic [XLEN-1:0] mis_addr_p0;

  // A trap in the same cycle drops the branch, so no report is raised for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_vld_p0  <= 1'b0;
      mis_addr_p0 <= '0;
    end else if ((state_p0 != BOOT) && bus.redir_valid && !bus.trap_valid && !redir_ok) begin
      mis_vld_p0  <= 1'b1;
      mis_addr_p0 <= redir_sum;
    end else begin
      mis_vld_p0  <= 1'b0;
      mis_addr_p0 <= '0;
    end
  end

  assign bus.misalign_valid = mis_vld_p0;
  assign bus.misalign_addr  = mis_addr_p0;
`else
  assign bus.misalign_valid = 1'b0;
  assign bus.misalign_addr  = '0;
`endif

  assign bus.if_valid = vld_p0;
  assign bus.if_pc    = pc_p0;
  assign bus.dnpc     = npc;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; expectations follow the build's
// PC_GEN_MISALIGN_CHK_EN setting.
module tb_pc_gen;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_redir(input logic v, input logic [31:0] b, input logic [31:0] o);
    bus.redir_valid = v;
    bus.redir_base  = b;
    bus.redir_off   = o;
  endtask

  task automatic set_trap(input logic v, input logic [31:0] t);
    bus.trap_valid = v;
    bus.trap_pc    = t;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.if_ready = 1'b1;
    bus.halt_req = 1'b0;
    set_redir(1'b0, 32'h0, 32'h0);
    set_trap(1'b0, 32'h0);

    // Reset state
    step();
    step();
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_if_pc", bus.if_pc, 32'h8000_0000);
    check("rst_dnpc", bus.dnpc, 32'h8000_0000);
    check("rst_mis_valid", {31'd0, bus.misalign_valid}, 32'd0);
    check("rst_mis_addr", bus.misalign_addr, 32'd0);

    // Release: BOOT cycle, then issue and step
    rst = 1'b1;
    settle();
    check("boot_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("boot_if_pc", bus.if_pc, 32'h8000_0000);
    step();
    check("run_if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("run_pc0", bus.if_pc, 32'h8000_0000);
    step();
    check("run_pc1", bus.if_pc, 32'h8000_0004);
    step();
    check("run_pc2", bus.if_pc, 32'h8000_0008);

    // Backpressure
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.if_pc, 32'h8000_0008);
      check("stall_valid", {31'd0, bus.if_valid}, 32'd1);
    end
    bus.if_ready = 1'b1;
    settle();
    check("stall_dnpc", bus.dnpc, 32'h8000_000C);
    step();
    check("stall_release_pc", bus.if_pc, 32'h8000_000C);

    // Trap beats branch and fetch acceptance
    set_trap(1'b1, 32'h8000_1000);
    set_redir(1'b1, 32'h8000_0000, 32'h0000_0020);
    settle();
    check("prio_dnpc", bus.dnpc, 32'h8000_1000);
    step();
    check("prio_pc", bus.if_pc, 32'h8000_1000);
    set_trap(1'b0, 32'h0);
    set_redir(1'b0, 32'h0, 32'h0);
    bus.if_ready = 1'b0;
    step();
    check("prio_no_branch", bus.if_pc, 32'h8000_1000);

    // Redirect while stalled, then wrap of sequential step
    set_redir(1'b1, 32'hFFFF_FFF0, 32'h0000_000C);
    step();
    check("flush_pc", bus.if_pc, 32'hFFFF_FFFC);
    set_redir(1'b0, 32'h0, 32'h0);
    bus.if_ready = 1'b1;
    settle();
    check("wrap_dnpc", bus.dnpc, 32'h0000_0000);
    step();
    check("wrap_pc", bus.if_pc, 32'h0000_0000);

    // Redirect with acceptance: no step, carry dropped
    set_redir(1'b1, 32'hFFFF_FFFC, 32'h0000_0008);
    step();
    check("redir_fire_pc", bus.if_pc, 32'h0000_0004);
    set_redir(1'b0, 32'h0, 32'h0);

    // Halt while not ready: address held until accepted
    bus.if_ready = 1'b0;
    bus.halt_req = 1'b1;
    step();
    check("halt_hold_valid", {31'd0, bus.if_valid}, 32'd1);
    check("halt_hold_pc", bus.if_pc, 32'h0000_0004);
    step();
    check("halt_hold_valid2", {31'd0, bus.if_valid}, 32'd1);
    bus.if_ready = 1'b1;
    step();
    check("halt_enter_valid", {31'd0, bus.if_valid}, 32'd0);
    check("halt_enter_pc", bus.if_pc, 32'h0000_0008);
    step();
    check("halt_stay_pc", bus.if_pc, 32'h0000_0008);
    check("halt_stay_valid", {31'd0, bus.if_valid}, 32'd0);
    set_redir(1'b1, 32'h8000_0100, 32'h0);
    step();
    check("halt_redir_pc", bus.if_pc, 32'h8000_0100);
    check("halt_redir_valid", {31'd0, bus.if_valid}, 32'd0);
    set_redir(1'b0, 32'h0, 32'h0);
    bus.halt_req = 1'b0;
    bus.if_ready = 1'b0;
    step();
    check("resume_valid", {31'd0, bus.if_valid}, 32'd1);
    check("resume_pc", bus.if_pc, 32'h8000_0100);

    // Misaligned branch targets
    set_trap(1'b1, 32'h8000_0000);
    step();
    check("trap_pc", bus.if_pc, 32'h8000_0000);
    set_trap(1'b0, 32'h0);
    set_redir(1'b1, 32'h8000_0000, 32'h0000_0002);
    step();
    check("mis2_pc", bus.if_pc, 32'h8000_0000);
`ifdef PC_GEN_MISALIGN_CHK_EN
    check("mis2_valid", {31'd0, bus.misalign_valid}, 32'd1);
    check("mis2_addr", bus.misalign_addr, 32'h8000_0002);
`else
    check("mis2_valid", {31'd0, bus.misalign_valid}, 32'd0);
    check("mis2_addr", bus.misalign_addr, 32'd0);
`endif
    set_redir(1'b1, 32'h8000_0000, 32'h0000_0013);
    step();
`ifdef PC_GEN_MISALIGN_CHK_EN
    check("mis13_pc", bus.if_pc, 32'h8000_0000);
    check("mis13_valid", {31'd0, bus.misalign_valid}, 32'd1);
    check("mis13_addr", bus.misalign_addr, 32'h8000_0013);
`else
    check("mis13_pc", bus.if_pc, 32'h8000_0010);
    check("mis13_valid", {31'd0, bus.misalign_valid}, 32'd0);
`endif
    set_redir(1'b0, 32'h0, 32'h0);
    step();
    check("mis_pulse_end", {31'd0, bus.misalign_valid}, 32'd0);
    bus.if_ready = 1'b1;
    step();
`ifdef PC_GEN_MISALIGN_CHK_EN
    check("pre_rst_pc", bus.if_pc, 32'h8000_0004);
`else
    check("pre_rst_pc", bus.if_pc, 32'h8000_0014);
`endif

    // Asynchronous reset mid-operation
    #2;
    rst = 1'b0;
    settle();
    check("arst_pc", bus.if_pc, 32'h8000_0000);
    check("arst_valid", {31'd0, bus.if_valid}, 32'd0);
    check("arst_dnpc", bus.dnpc, 32'h8000_0000);

    // Halt held through BOOT, trap ignored in BOOT
    bus.halt_req = 1'b1;
    step();
    rst = 1'b1;
    set_trap(1'b1, 32'h0000_1234);
    settle();
    check("boot_trap_dnpc", bus.dnpc, 32'h8000_0000);
    set_trap(1'b0, 32'h0);
    step();
    check("boot_halt_valid", {31'd0, bus.if_valid}, 32'd0);
    check("boot_halt_pc", bus.if_pc, 32'h8000_0000);
    bus.halt_req = 1'b0;
    step();
    check("boot_resume_valid", {31'd0, bus.if_valid}, 32'd1);
    step();
    check("boot_resume_pc", bus.if_pc, 32'h8000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
